// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: control inputs, BROM port and decode handshake.
// The master side drives control, BROM data and decode ready.
// The slave side is the sequencer itself.
interface fetch_sequencer_if #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  start;
    logic                  redirect_valid;
    logic [PC_WIDTH-1:0]   redirect_pc;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_rdata;
    logic                  instr_valid;
    logic [31:0]           instr;
    logic [PC_WIDTH-1:0]   instr_pc;
    logic                  instr_ready;
    logic                  halted;
    logic                  busy;

    modport master (
        output start, redirect_valid, redirect_pc, mem_rdata, instr_ready,
        input  mem_addr, instr_valid, instr, instr_pc, halted, busy
    );

    modport slave (
        input  start, redirect_valid, redirect_pc, mem_rdata, instr_ready,
        output mem_addr, instr_valid, instr, instr_pc, halted, busy
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one BROM word address per cycle,
// buffers returned words in a 2-entry queue for decode, squashes wrong-path
// fetches on redirect, and stops fetching when the halt word is read.
module fetch_sequencer #(
    parameter int unsigned         PC_WIDTH   = 32,
    parameter int unsigned         ADDR_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [31:0]         HALT_WORD  = 32'hFFFF_FFFF
) (
    input logic               clk,
    input logic               rst_n,
    fetch_sequencer_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                inflight_q, inflight_d;
    logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [31:0]         q_instr_q [2];
    logic [31:0]         q_instr_d [2];
    logic [PC_WIDTH-1:0] q_pc_q [2];
    logic [PC_WIDTH-1:0] q_pc_d [2];
    logic [1:0]          count_q, count_d;

    logic       headValid;
    logic       pop;
    logic       redirect;
    logic       ret;
    logic       haltRet;
    logic       push;
    logic [2:0] occ;
    logic       issue;
    logic       wIdx;

    // Handshake, squash and issue decisions for the current cycle.
    // A returning halt word also blocks issue so the PC freezes on the
    // first address that was never fetched.
    always_comb begin
        headValid = (count_q != 2'd0);
        pop       = headValid & bus.instr_ready;
        redirect  = bus.redirect_valid & (state_q != S_HALT);
        ret       = inflight_q & ~redirect;
        haltRet   = ret & (bus.mem_rdata == HALT_WORD);
        push      = ret & ~haltRet;
        occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (state_q == S_FETCH) & ~redirect & ~haltRet & (occ < 3'd2);
        wIdx      = count_q[1] | (count_q[0] & ~pop);
    end

    // Next-state for FSM, PC and the single outstanding BROM read.
    // The BROM always answers one cycle later, so inflight simply records issue.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_FETCH;
            S_FETCH: if (haltRet)   state_d = S_HALT;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        if (redirect) begin
            pc_d = bus.redirect_pc;
        end else if (issue) begin
            pc_d          = pc_q + 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    // Queue update: redirect flushes; otherwise shift on pop and write the
    // tail slot that is free after the pop.
    always_comb begin
        q_instr_d = q_instr_q;
        q_pc_d    = q_pc_q;
        count_d   = count_q;
        if (redirect) begin
            count_d = 2'd0;
        end else begin
            if (pop) begin
                q_instr_d[0] = q_instr_q[1];
                q_pc_d[0]    = q_pc_q[1];
            end
            if (push) begin
                q_instr_d[wIdx] = bus.mem_rdata;
                q_pc_d[wIdx]    = inflight_pc_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            q_instr_q[0]  <= '0;
            q_instr_q[1]  <= '0;
            q_pc_q[0]     <= '0;
            q_pc_q[1]     <= '0;
            count_q       <= 2'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            q_instr_q     <= q_instr_d;
            q_pc_q        <= q_pc_d;
            count_q       <= count_d;
        end
    end

    assign bus.mem_addr    = pc_q[ADDR_WIDTH-1:0];
    assign bus.instr_valid = headValid;
    assign bus.instr       = q_instr_q[0];
    assign bus.instr_pc    = q_pc_q[0];
    assign bus.halted      = (state_q == S_HALT);
    assign bus.busy        = (state_q == S_FETCH) | headValid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one instance with RESET_PC=0 and one
// with RESET_PC=all-ones for the wrap case, both reading a shared BROM model.
module tb_fetch_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.PC_WIDTH(32), .ADDR_WIDTH(12)) busA ();
    fetch_sequencer_if #(.PC_WIDTH(32), .ADDR_WIDTH(12)) busW ();

    logic [31:0] rom [4096];

    // Synchronous-read BROM models, one read port per instance.
    always @(posedge clk) busA.mem_rdata <= rom[busA.mem_addr];
    always @(posedge clk) busW.mem_rdata <= rom[busW.mem_addr];

    fetch_sequencer #(
        .PC_WIDTH(32), .ADDR_WIDTH(12), .RESET_PC(32'h0), .HALT_WORD(HALT)
    ) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA)
    );

    fetch_sequencer #(
        .PC_WIDTH(32), .ADDR_WIDTH(12), .RESET_PC(32'hFFFF_FFFF), .HALT_WORD(HALT)
    ) dutW (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busW)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] rpc, input logic rdy);
        busA.start          = s;
        busA.redirect_valid = rv;
        busA.redirect_pc    = rpc;
        busA.instr_ready    = rdy;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        busW.start = 1'b0; busW.redirect_valid = 1'b0; busW.redirect_pc = '0; busW.instr_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 32'hA000_0000 + i;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        busW.start = 1'b0; busW.redirect_valid = 1'b0; busW.redirect_pc = '0; busW.instr_ready = 1'b0;

        $display("[TB] reset state");
        tick();
        tick();
        checkOutput("rst_valid",   {31'b0, busA.instr_valid}, 32'd0);
        checkOutput("rst_instr",   busA.instr,                32'd0);
        checkOutput("rst_pc",      busA.instr_pc,             32'd0);
        checkOutput("rst_halted",  {31'b0, busA.halted},      32'd0);
        checkOutput("rst_busy",    {31'b0, busA.busy},        32'd0);
        checkOutput("rst_addr",    {20'b0, busA.mem_addr},    32'h000);
        checkOutput("rst_addr_w",  {20'b0, busW.mem_addr},    32'hFFF);
        rst_n = 1'b1;
        tick();

        $display("[TB] streaming with ready high");
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("s1_issue_addr", {20'b0, busA.mem_addr},   32'h000);
        checkOutput("s1_busy",       {31'b0, busA.busy},       32'd1);
        checkOutput("s1_valid_t0",   {31'b0, busA.instr_valid}, 32'd0);
        tick();
        checkOutput("s1_valid_t1",   {31'b0, busA.instr_valid}, 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            checkOutput("s1_valid", {31'b0, busA.instr_valid}, 32'd1);
            checkOutput("s1_instr", busA.instr,    32'hA000_0000 + k);
            checkOutput("s1_pc",    busA.instr_pc, k);
            tick();
        end

        $display("[TB] backpressure");
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        checkOutput("s2_addr_t2", {20'b0, busA.mem_addr}, 32'h002);
        tick();
        checkOutput("s2_addr_t3", {20'b0, busA.mem_addr}, 32'h002);
        checkOutput("s2_head_t3", busA.instr,    32'hA000_0000);
        tick();
        checkOutput("s2_addr_t4", {20'b0, busA.mem_addr}, 32'h002);
        checkOutput("s2_pc_t4",   busA.instr_pc, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("s2_valid", {31'b0, busA.instr_valid}, 32'd1);
            checkOutput("s2_pc",    busA.instr_pc, k);
            checkOutput("s2_instr", busA.instr,    32'hA000_0000 + k);
            tick();
        end

        $display("[TB] redirect flushes queue");
        doReset();
        applyStimulus(1'b0, 1'b1, 32'd5, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("s3_idle_addr", {20'b0, busA.mem_addr}, 32'h005);
        checkOutput("s3_idle_busy", {31'b0, busA.busy},     32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("s3_full_pc",   busA.instr_pc,          32'd5);
        checkOutput("s3_full_addr", {20'b0, busA.mem_addr}, 32'h007);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("s3_r1_valid", {31'b0, busA.instr_valid}, 32'd0);
        checkOutput("s3_r1_addr",  {20'b0, busA.mem_addr},    32'h040);
        tick();
        checkOutput("s3_r2_valid", {31'b0, busA.instr_valid}, 32'd0);
        tick();
        checkOutput("s3_r3_valid", {31'b0, busA.instr_valid}, 32'd1);
        checkOutput("s3_r3_pc",    busA.instr_pc, 32'h40);
        checkOutput("s3_r3_instr", busA.instr,    32'hA000_0040);
        tick();
        checkOutput("s3_r4_pc",    busA.instr_pc, 32'h41);

        $display("[TB] halt word");
        rom[2] = HALT;
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        tick();
        checkOutput("s4_a_pc",    busA.instr_pc, 32'd0);
        tick();
        checkOutput("s4_b_pc",    busA.instr_pc, 32'd1);
        checkOutput("s4_b_halt",  {31'b0, busA.halted}, 32'd0);
        checkOutput("s4_b_busy",  {31'b0, busA.busy},   32'd1);
        tick();
        checkOutput("s4_halted",  {31'b0, busA.halted},      32'd1);
        checkOutput("s4_busy",    {31'b0, busA.busy},        32'd0);
        checkOutput("s4_valid",   {31'b0, busA.instr_valid}, 32'd0);
        checkOutput("s4_addr",    {20'b0, busA.mem_addr},    32'h003);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h20, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("s4_frozen_addr", {20'b0, busA.mem_addr},    32'h003);
        checkOutput("s4_still_halt",  {31'b0, busA.halted},      32'd1);
        tick();
        checkOutput("s4_no_valid",    {31'b0, busA.instr_valid}, 32'd0);

        $display("[TB] redirect squashes halt");
        doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        tick();
        tick();
        applyStimulus(1'b0, 1'b1, 32'h10, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("s5_r1_halt",  {31'b0, busA.halted},      32'd0);
        checkOutput("s5_r1_valid", {31'b0, busA.instr_valid}, 32'd0);
        checkOutput("s5_r1_addr",  {20'b0, busA.mem_addr},    32'h010);
        tick();
        checkOutput("s5_r2_valid", {31'b0, busA.instr_valid}, 32'd0);
        tick();
        checkOutput("s5_r3_pc",    busA.instr_pc, 32'h10);
        checkOutput("s5_r3_instr", busA.instr,    32'hA000_0010);
        tick();
        checkOutput("s5_r4_pc",    busA.instr_pc, 32'h11);
        checkOutput("s5_r4_halt",  {31'b0, busA.halted}, 32'd0);
        rom[2] = 32'hA000_0002;

        $display("[TB] pc wrap and async reset");
        doReset();
        busW.start = 1'b1; busW.instr_ready = 1'b1;
        tick();
        busW.start = 1'b0;
        checkOutput("s6_addr_t0", {20'b0, busW.mem_addr}, 32'hFFF);
        tick();
        checkOutput("s6_addr_t1", {20'b0, busW.mem_addr}, 32'h000);
        tick();
        checkOutput("s6_pc0",     busW.instr_pc, 32'hFFFF_FFFF);
        checkOutput("s6_instr0",  busW.instr,    32'hA000_0FFF);
        checkOutput("s6_addr_t2", {20'b0, busW.mem_addr}, 32'h001);
        tick();
        checkOutput("s6_pc1",     busW.instr_pc, 32'h0);
        tick();
        checkOutput("s6_pc2",     busW.instr_pc, 32'h1);
        checkOutput("s6_busy",    {31'b0, busW.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("s6_rst_valid", {31'b0, busW.instr_valid}, 32'd0);
        checkOutput("s6_rst_busy",  {31'b0, busW.busy},        32'd0);
        checkOutput("s6_rst_halt",  {31'b0, busW.halted},      32'd0);
        checkOutput("s6_rst_addr",  {20'b0, busW.mem_addr},    32'hFFF);
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch controller sitting between the program counter logic and the instruction BROM (synchronous read, 1-cycle latency, no enable). It owns the PC and issues one word address per cycle. It captures returned words into a 2-entry instruction queue and hands them to decode over a valid/ready handshake. It also squashes wrong-path fetches on branch redirect and stops fetching when a halt word is read.

## Interface
- PC_WIDTH, 32, program counter width (word address)
- ADDR_WIDTH, 12, BROM address width; `mem_addr = pc[ADDR_WIDTH-1:0]`
- RESET_PC, 0, PC value after reset
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- start  in  1  one-cycle pulse; begins fetching from current PC (IDLE only)
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  PC_WIDTH  target word address
- mem_addr  out  ADDR_WIDTH  BROM address, combinational from PC register
- mem_rdata  in  32  BROM data; corresponds to mem_addr of previous cycle
- instr_valid  out  1  queue head valid
- instr  out  32  queue head instruction
- instr_pc  out  PC_WIDTH  word address of instr
- instr_ready  in  1  decode accepts head this cycle
- halted  out  1  state == HALT
- busy  out  1  state == FETCH or queue non-empty

## Operation
- Reset values:
  - state = IDLE, pc = RESET_PC
  - inflight = 0, queue empty
  - instr_valid = 0, instr = 0, instr_pc = 0
  - halted = 0, busy = 0
- States:
  - IDLE: no issue. `start` moves to FETCH. `redirect_valid` loads pc but stays in IDLE.
  - FETCH: issue rule below.
  - HALT: no issue; redirect and start are ignored; exit only by reset.
- Issue rule (FETCH, no redirect this cycle): let `cnt = occupancy + inflight - (instr_valid & instr_ready)`. Issue when `cnt < 2`.
- An issue does three things: sets inflight=1, sets inflight_pc=pc, and sets pc=pc+1. PC wraps mod 2^PC_WIDTH; mem_addr truncates.
- Return (inflight==1, not squashed, no redirect this cycle):
  - mem_rdata == HALT_WORD: word is not enqueued. State moves to HALT. Inflight clears.
  - Otherwise: {mem_rdata, inflight_pc} is pushed to the queue tail.
- Queue: 2-entry FIFO with head on instr/instr_pc. Pop occurs when `instr_valid & instr_ready`. Push and pop in the same cycle are legal at any occupancy; overflow cannot occur by the issue rule.
- Redirect (FETCH or IDLE) has highest priority:
  - flushes the queue
  - drops any inflight return, even one equal to HALT_WORD
  - pc = redirect_pc
  - no issue that cycle
  - instr_valid = 0 next cycle
- Redirect coincident with a pop: the pop is irrelevant because the flush wins.
- Redirect coincident with `start` in IDLE: pc loads and the state moves to FETCH.
- HALT: queued older instructions still drain normally. busy falls when the queue empties.

## Timing
- The BROM read is registered. Data for an address issued in cycle t appears on mem_rdata in cycle t+1 and is pushed at the end of t+1. instr_valid is high in t+2.
- Start latency: start sampled at edge E0. First issue occurs in the following cycle, and the first instr_valid is 2 cycles after that issue.
- With instr_ready held high, the sustained rate is 1 instruction per cycle.
- With instr_ready held low, issue stops after 2 words (queue full, inflight 0). The mem_addr value is then stable at the next unfetched PC.
- After redirect in cycle r:
  - first issue of redirect_pc in r+1
  - instr_valid low in r+1 and r+2
  - instr_valid high in r+3 with instr_pc = redirect_pc
- halted rises the cycle after HALT_WORD appears on mem_rdata.
- Reset asserted mid-fetch returns all outputs to reset values asynchronously. Deassertion is synchronized by the integrator.

## Test plan
- Reset then start with ROM[0..3]=A,B,C,D and ready=1: instr_valid first high 2 cycles after the first issue, then A,B,C,D on consecutive cycles with instr_pc 0,1,2,3.
- ready=0 for 5 cycles after start: exactly 2 entries are held (A then B). mem_addr stays at 2. On release, the bench sees A,B,C with no gaps or duplicates.
- Redirect to 0x40 while entries sit at pc 5,6: both are dropped. The next valid is instr_pc=0x40 three cycles after the redirect. No pc 7 instruction appears.
- ROM[2]=HALT_WORD, ready=1: A,B are delivered, and the halt word and ROM[3] are never delivered. halted=1, busy falls after B pops, and mem_addr is frozen.
- Redirect in the same cycle that HALT_WORD returns: halt is squashed, halted stays 0, and fetch resumes at the target.
- PC wrap with RESET_PC=0xFFFF_FFFF: instr_pc sequence FFFF_FFFF, 0, 1; mem_addr 0xFFF, 0x000, 0x001. Reset asserted mid-stream then clears instr_valid, busy and halted at once.
